// File: rtl/issue_pkg.sv
// Shared unit ids and CDB select encoding for the issue scheduler and CDB mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package issue_pkg;

    localparam int NUM_UNITS = 4;
    localparam int CDB_SEL_W = 2;

    // Unit id doubles as the cdb_sel encoding seen by the CDB mux.
    typedef logic [CDB_SEL_W-1:0] unit_id_t;

    localparam unit_id_t UNIT_INT_A = 2'd0;
    localparam unit_id_t UNIT_INT_B = 2'd1;
    localparam unit_id_t UNIT_LD_ST = 2'd2;
    localparam unit_id_t UNIT_MUL   = 2'd3;

    // Convert a one-hot grant vector into the granted unit id (0 when empty).
    function automatic unit_id_t onehot_to_id(input logic [NUM_UNITS-1:0] oh);
        unit_id_t id;
        id = UNIT_INT_A;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (oh[i]) begin
                id = unit_id_t'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/issue_rr_arbiter4.sv
// Four-request rotating-priority arbiter: ptr names the highest-priority request.
// Latency: combinational, zero cycles.
// Backpressure: none; requests already filtered for eligibility upstream.
module rr_arbiter4
    import issue_pkg::*;
(
    input  logic [3:0] req,
    input  unit_id_t   ptr,
    output logic [3:0] grant,
    output unit_id_t   ptr_next
);

    unit_id_t idx;
    logic     found;

    // Scan ptr, ptr+1, ptr+2, ptr+3 and grant the first request; ptr moves past the winner.
    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + unit_id_t'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                ptr_next   = idx + 2'd1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_unit.sv
// Single-issue scheduler: grants one ready queue per cycle whose result slot on the CDB is free.
// Latency: grants are combinational (0 cycles); a grant reaches the CDB L cycles later.
// Backpressure: a ready queue is held off while its CDB slot is reserved or flush is high.
// Optional ISSUE_STALL_CNT_EN adds a 16-bit saturating counter of CDB-conflict stall cycles.
module issue_unit
    import issue_pkg::*;
#(
    parameter int INT_LAT  = 1,
    parameter int LDST_LAT = 2,
    parameter int MUL_LAT  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        int_a_ready,
    input  logic        int_b_ready,
    input  logic        ld_st_ready,
    input  logic        mul_ready,
    output logic        issue_int_a,
    output logic        issue_int_b,
    output logic        issue_ld_st,
    output logic        issue_mul,
    output logic [1:0]  cdb_sel,
    output logic        cdb_sel_valid
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [15:0] issue_stall_cnt
`endif
);

    // Latencies must satisfy 1 <= INT_LAT <= LDST_LAT <= MUL_LAT <= 8.

    // Entry k describes CDB cycle t+k; the top slot busy[MUL_LAT] is always free.
    logic [MUL_LAT-1:0] busy;
    logic [MUL_LAT-1:0] busy_n;
    unit_id_t           own   [MUL_LAT];
    unit_id_t           own_n [MUL_LAT];
    logic [MUL_LAT:0]   busy_ext;

    unit_id_t   ptr;
    unit_id_t   ptr_next;
    logic [3:0] ready_vec;
    logic [3:0] free_vec;
    logic [3:0] elig;
    logic [3:0] grant;
    logic       grant_any;
    unit_id_t   gnt_id;
    int         gnt_lat;

    assign busy_ext  = {1'b0, busy};
    assign ready_vec = {mul_ready, ld_st_ready, int_b_ready, int_a_ready};
    assign free_vec  = {~busy_ext[MUL_LAT], ~busy_ext[LDST_LAT],
                        ~busy_ext[INT_LAT], ~busy_ext[INT_LAT]};
    // Flush squashes issue; reset is also folded in so grants read 0 while reset is held.
    assign elig      = (flush || !reset) ? 4'b0000 : (ready_vec & free_vec);

    rr_arbiter4 u_arb (
        .req      (elig),
        .ptr      (ptr),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

    assign grant_any   = |grant;
    assign gnt_id      = onehot_to_id(grant);
    assign issue_int_a = grant[UNIT_INT_A];
    assign issue_int_b = grant[UNIT_INT_B];
    assign issue_ld_st = grant[UNIT_LD_ST];
    assign issue_mul   = grant[UNIT_MUL];

    assign cdb_sel       = own[0];
    assign cdb_sel_valid = busy[0];

    // Pick the fixed execution latency of the granted unit.
    always_comb begin
        gnt_lat = MUL_LAT;
        case (gnt_id)
            UNIT_INT_A: gnt_lat = INT_LAT;
            UNIT_INT_B: gnt_lat = INT_LAT;
            UNIT_LD_ST: gnt_lat = LDST_LAT;
            default:    gnt_lat = MUL_LAT;
        endcase
    end

    // Shift the reservation table down one cycle and book the granted result slot.
    always_comb begin
        busy_n = '0;
        for (int k = 0; k < MUL_LAT; k++) begin
            own_n[k] = UNIT_INT_A;
        end
        if (!flush) begin
            for (int k = 0; k < MUL_LAT - 1; k++) begin
                busy_n[k] = busy[k+1];
                own_n[k]  = own[k+1];
            end
            for (int k = 0; k < MUL_LAT; k++) begin
                if (grant_any && (k == gnt_lat - 1)) begin
                    busy_n[k] = 1'b1;
                    own_n[k]  = gnt_id;
                end
            end
        end
    end

    // Reservation table and priority pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
            ptr  <= UNIT_INT_A;
            for (int k = 0; k < MUL_LAT; k++) begin
                own[k] <= UNIT_INT_A;
            end
        end else begin
            busy <= busy_n;
            ptr  <= ptr_next;
            for (int k = 0; k < MUL_LAT; k++) begin
                own[k] <= own_n[k];
            end
        end
    end

`ifdef ISSUE_STALL_CNT_EN
    logic stall_cycle;

    assign stall_cycle = !flush && (|ready_vec) && !grant_any;

    // Count cycles where something was ready but every ready queue hit a booked CDB slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_stall_cnt <= '0;
        end else if (stall_cycle && (issue_stall_cnt != 16'hFFFF)) begin
            issue_stall_cnt <= issue_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/issue_unit.md
# issue_unit

Single-issue scheduler between the four reservation/issue queues (integer A, integer B, load/store, multiply) and the shared Common Data Bus (CDB). Each cycle it grants at most one ready queue, using rotating priority. It only grants a queue whose fixed execution latency lands on a CDB cycle that is not already reserved. It also tells the CDB mux which unit drives the bus in the current cycle.

## Interface
Parameters:
- `INT_LAT`, default 1: cycles from issue to CDB for integer A/B.
- `LDST_LAT`, default 2: cycles from issue to CDB for load/store.
- `MUL_LAT`, default 4: cycles from issue to CDB for multiply.
- Legal range: 1 ≤ INT_LAT ≤ LDST_LAT ≤ MUL_LAT ≤ 8.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  branch mispredict flush from retire.
- `int_a_ready`  in  1  integer queue A holds an issuable entry.
- `int_b_ready`  in  1  integer queue B holds an issuable entry.
- `ld_st_ready`  in  1  load/store queue holds an issuable entry.
- `mul_ready`  in  1  multiply queue holds an issuable entry.
- `issue_int_a`  out  1  grant, combinational; queue A dequeues this cycle.
- `issue_int_b`  out  1  grant to queue B.
- `issue_ld_st`  out  1  grant to load/store queue.
- `issue_mul`  out  1  grant to multiply queue.
- `cdb_sel`  out  2  unit driving the CDB this cycle: 00 int_a, 01 int_b, 10 ld_st, 11 mul.
- `cdb_sel_valid`  out  1  the CDB carries a result this cycle.
- `issue_stall_cnt`  out  16  conflict-stall counter; present only with `ISSUE_STALL_CNT_EN`.

## Operation
- Reservation table: registers `busy[k]` and `own[k]` (2 bits) for k = 0..MUL_LAT-1.
  - At cycle t, entry k describes CDB cycle t+k.
  - `busy[MUL_LAT]` is treated as constant 0.
- Eligibility: a requester with latency L is eligible iff ready=1 and `busy[L]`=0.
  - Multiply is therefore never blocked by an existing reservation.
- Arbitration uses a 2-bit rotating pointer `ptr` that names the highest-priority requester.
  - Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first eligible requester is granted.
  - After a grant to unit u, `ptr` ← u+1 mod 4.
  - With no grant, `ptr` holds.
- Update every edge:
  - busy_next[k] = busy[k+1], own_next[k] = own[k+1].
  - On a grant with latency L: busy_next[L-1] = 1 and own_next[L-1] = unit id.
  - That slot is guaranteed free by the eligibility check.
- Outputs: `cdb_sel` = `own[0]`, `cdb_sel_valid` = `busy[0]`.
- Grant vector is one-hot or all zero; never more than one grant per cycle.
- Flush:
  - During a cycle with flush=1, all grants are forced to 0.
  - At that edge every busy/own entry clears, because the execution units squash all in-flight ops.
  - `ptr` is unchanged.
- Ready deasserted in the same cycle as a would-be grant: no grant. Grants depend on the current-cycle ready only.

## Timing
- Grant latency: 0 cycles, combinational from ready and registered state. Queues sample the grant at the same edge.
- A result issued at cycle t appears with `cdb_sel_valid`=1 at cycle t+L.
- Reset (reset=0, asynchronous):
  - busy, own and ptr are 0 (int_a highest priority).
  - All grants 0, `cdb_sel`=00, `cdb_sel_valid`=0, `issue_stall_cnt`=0.
- Reset asserted mid-operation discards all reservations immediately. Outputs reach reset values without waiting for a clock.

## Configuration
`ISSUE_STALL_CNT_EN` controls the conflict-stall counter.
- Defined:
  - Adds port `issue_stall_cnt`, a 16-bit saturating counter (holds at FFFF).
  - It increments on every non-flush cycle in which at least one queue is ready and no grant occurs, i.e. all ready requesters are CDB-blocked.
  - It clears on reset only.
- Undefined: the port and the counter logic are absent. Scheduling behaviour is identical in both cases.

## Structure
- Shared package `issue_pkg` holds:
  - unit-id constants `UNIT_INT_A`=0, `UNIT_INT_B`=1, `UNIT_LD_ST`=2, `UNIT_MUL`=3;
  - the 2-bit `unit_id_t` typedef;
  - the `cdb_sel` encoding, also used by the CDB mux.
- One sub-module is natural: `rr_arbiter4`, a 4-request rotating-priority arbiter. It takes an eligible vector and ptr, and returns a one-hot grant plus the next ptr.
- The reservation shift register and the stall counter stay in the top level.

## Test plan
- Reset, then int_a_ready=1 at cycle 1 → issue_int_a=1 at cycle 1; cdb_sel=00 with cdb_sel_valid=1 at cycle 2.
- mul_ready pulse at t0 (MUL_LAT=4), int_a_ready held from t3 → int_a blocked at t3 and granted at t4; CDB shows mul (11) at t4 and int_a (00) at t5.
- mul at t0, ld_st_ready at t2 (LDST_LAT=2) → ld_st blocked at t2 and granted at t3; CDB shows ld_st (10) at t5.
- All four ready continuously from reset with latencies all 1 → grants rotate int_a, int_b, ld_st, mul, int_a… one per cycle.
- mul at t0, flush=1 at t2 → no grant at t2; cdb_sel_valid stays 0 at t4.
- With `ISSUE_STALL_CNT_EN`: mul at t0, only int_a ready at t3 → issue_stall_cnt goes from 0 to 1 after t3; async reset mid-run → all outputs 0 immediately.
